// File: rtl/challenge_sequencer_pkg.sv
// Purpose   : shared types and constants for the challenge sequencer slice.
// Latency   : n/a (declarations only).
// Backpressure: n/a.
package challenge_seq_pkg;

  localparam int CHALLENGE_W = 8;
  localparam int SWEEP_LEN   = 256;

  typedef logic [CHALLENGE_W-1:0] chal_t;

  typedef enum logic [2:0] {
    IDLE,
    RESET_SCR,
    SETTLE,
    OUTPUT,
    DONE
  } state_t;

endpackage

// File: rtl/challenge_sequencer_settle_timer.sv
// Purpose   : counts settle cycles; terminal pulses on the last counted cycle.
// Latency   : terminal is combinational from the count (SETTLE_CYCLES cycles after clear).
// Backpressure: none; counts only while en is high, holds otherwise.
//
// Ports: clk, rst (async active-low), clear (zero the count), en (advance),
//        terminal (en && count == SETTLE_CYCLES-1).
module settle_timer #(
  parameter int SETTLE_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign terminal = en && (count == LAST);

endmodule

// File: rtl/challenge_sequencer.sv
// Purpose   : sweeps all 256 challenges through the scrambler and streams CRPs.
// Latency   : SETTLE_CYCLES+2 cycles per CRP with crp_ready high; crp_valid at E(SETTLE_CYCLES+1).
// Backpressure: crp_ready low holds OUTPUT (and the captured CRP) indefinitely.
//
// Ports: clk, rst (async active-low), start (sampled in IDLE only),
//        scr_rst/scr_challenge/scr_response (scrambler side),
//        crp_valid/crp_ready/crp_challenge/crp_response (CRP stream),
//        busy (not IDLE), done (one cycle after the 256th handshake).
// Optional: define CHALLENGE_SEQ_PARITY_EN to add crp_parity = ^{crp_challenge, crp_response}.
module challenge_sequencer
  import challenge_seq_pkg::*;
#(
  parameter int          SETTLE_CYCLES   = 255,
  parameter logic [7:0]  START_CHALLENGE = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       scr_rst,
  output logic [7:0] scr_challenge,
  input  logic [7:0] scr_response,
  output logic       crp_valid,
  input  logic       crp_ready,
  output logic [7:0] crp_challenge,
  output logic [7:0] crp_response,
  output logic       busy,
  output logic       done
`ifdef CHALLENGE_SEQ_PARITY_EN
  ,
  output logic       crp_parity
`endif
);

  // The sweep ends on the challenge just before the starting one (mod 256).
  localparam chal_t LAST_CHAL = START_CHALLENGE - 8'd1;

  state_t state;
  chal_t  chal_reg;
  logic   settle_last;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == RESET_SCR),
    .en       (state == SETTLE),
    .terminal (settle_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      chal_reg      <= START_CHALLENGE;
      scr_rst       <= 1'b0;
      scr_challenge <= START_CHALLENGE;
      crp_valid     <= 1'b0;
      crp_challenge <= 8'h00;
      crp_response  <= 8'h00;
      done          <= 1'b0;
`ifdef CHALLENGE_SEQ_PARITY_EN
      crp_parity    <= 1'b0;
`endif
    end else begin
      // Both pulses last exactly one cycle unless re-armed below.
      scr_rst <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            scr_rst       <= 1'b1;
            scr_challenge <= chal_reg;
            state         <= RESET_SCR;
          end
        end
        RESET_SCR: begin
          state <= SETTLE;
        end
        SETTLE: begin
          if (settle_last) begin
            crp_response  <= scr_response;
            crp_challenge <= chal_reg;
            crp_valid     <= 1'b1;
`ifdef CHALLENGE_SEQ_PARITY_EN
            crp_parity    <= ^{chal_reg, scr_response};
`endif
            state         <= OUTPUT;
          end
        end
        OUTPUT: begin
          // Captured response is held; scr_response is not looked at here.
          if (crp_ready) begin
            crp_valid <= 1'b0;
            if (chal_reg == LAST_CHAL) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              chal_reg      <= chal_reg + 8'd1;
              scr_challenge <= chal_reg + 8'd1;
              scr_rst       <= 1'b1;
              state         <= RESET_SCR;
            end
          end
        end
        DONE: begin
          chal_reg <= START_CHALLENGE;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_challenge_sequencer.sv
// Scoreboard bench: each accepted start pushes the full expected CRP sweep into
// a queue; a negedge monitor checks the stream, timing and status outputs.
module tb_challenge_sequencer;

  localparam int         S     = 4;
  localparam logic [7:0] START = 8'h01;
  localparam int         SWEEP = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       scr_rst;
  logic [7:0] scr_challenge;
  logic [7:0] scr_response;
  logic       crp_valid;
  logic       crp_ready = 1'b1;
  logic [7:0] crp_challenge;
  logic [7:0] crp_response;
  logic       busy;
  logic       done;
`ifdef CHALLENGE_SEQ_PARITY_EN
  logic       crp_parity;
`endif

  always #5 clk = ~clk;

  challenge_sequencer #(
    .SETTLE_CYCLES  (S),
    .START_CHALLENGE(START)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .scr_rst      (scr_rst),
    .scr_challenge(scr_challenge),
    .scr_response (scr_response),
    .crp_valid    (crp_valid),
    .crp_ready    (crp_ready),
    .crp_challenge(crp_challenge),
    .crp_response (crp_response),
    .busy         (busy),
    .done         (done)
`ifdef CHALLENGE_SEQ_PARITY_EN
    ,
    .crp_parity   (crp_parity)
`endif
  );

  // Scrambler stub: output is only correct 3..5 cycles after its reset pulse,
  // garbage before (capture too early) and after (re-sampling during a stall).
  logic [7:0] mask = 8'hA5;
  logic [2:0] stub_cnt = 3'd0;
  always @(posedge clk) begin
    if (scr_rst === 1'b1) stub_cnt <= 3'd0;
    else if (stub_cnt != 3'd7) stub_cnt <= stub_cnt + 3'd1;
  end
  assign scr_response = (stub_cnt >= 3'd3 && stub_cnt <= 3'd5) ? (scr_challenge ^ mask)
                                                               : ~(scr_challenge ^ mask);

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cycle index: value of cyc after edge k is k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state (sweep-level view).
  logic [15:0] q[$];
  int anchor = -1;       // edge at which the current challenge's scr_rst pulse starts
  int sweep_start = -1;
  int sweep_end = -1;    // edge of the 256th handshake (done high during that cycle)
  int hs_cnt = 0;
  bit in_flight = 1'b0;
  int done_seen = -1;

  bit rand_ready = 1'b0;
  bit force_low = 1'b0;
  always @(posedge clk) begin
    #1;
    crp_ready = force_low ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  bit exp_valid, exp_rst, exp_busy, exp_done;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      exp_valid = in_flight && anchor >= 0 && cyc >= anchor + S + 1;
      exp_rst   = anchor >= 0 && cyc == anchor;
      exp_busy  = sweep_start >= 0 && cyc >= sweep_start && (sweep_end < 0 || cyc <= sweep_end);
      exp_done  = sweep_end >= 0 && cyc == sweep_end;
      chk("crp_valid", crp_valid, exp_valid);
      chk("scr_rst", scr_rst, exp_rst);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      if (done === 1'b1) done_seen = cyc;
      if (exp_rst && q.size() > 0) chk("scr_challenge", scr_challenge, q[0][15:8]);
      if (crp_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL crp_unexpected: got %0h/%0h, expected no CRP", crp_challenge, crp_response);
        end else begin
          chk("crp_challenge", crp_challenge, q[0][15:8]);
          chk("crp_response", crp_response, q[0][7:0]);
`ifdef CHALLENGE_SEQ_PARITY_EN
          chk("crp_parity", crp_parity, ^q[0]);
`endif
          if (crp_ready === 1'b1) begin
            void'(q.pop_front());
            hs_cnt++;
            if (hs_cnt == SWEEP) begin
              sweep_end = cyc + 1;
              in_flight = 1'b0;
            end else begin
              anchor = cyc + 1;
            end
          end
        end
      end
    end
  end

  // Called just after a rising edge; asserts reset mid-cycle and checks
  // that outputs reach reset values before the next edge.
  task automatic do_reset();
    #1 rst = 1'b0;
    #1;
    chk("rst_scr_rst", scr_rst, 1'b0);
    chk("rst_scr_challenge", scr_challenge, START);
    chk("rst_crp_valid", crp_valid, 1'b0);
    chk("rst_crp_challenge", crp_challenge, 8'h00);
    chk("rst_crp_response", crp_response, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
`ifdef CHALLENGE_SEQ_PARITY_EN
    chk("rst_crp_parity", crp_parity, 1'b0);
`endif
    q.delete();
    anchor = -1;
    sweep_start = -1;
    sweep_end = -1;
    hs_cnt = 0;
    in_flight = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Called just after a rising edge; start is sampled at the next edge.
  task automatic pulse_start(input bit accept);
    logic [7:0] c;
    start = 1'b1;
    if (accept) begin
      anchor = cyc + 1;
      sweep_start = cyc + 1;
      sweep_end = -1;
      hs_cnt = 0;
      in_flight = 1'b1;
      q.delete();
      for (int i = 0; i < SWEEP; i++) begin
        c = START + 8'(i);
        q.push_back({c, c ^ mask});
      end
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_sweep(input string nm, input int budget);
    int n;
    n = 0;
    while (!(sweep_end >= 0 && cyc > sweep_end) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, (sweep_end >= 0 && cyc > sweep_end), 1'b1);
    chk({nm, "_queue_empty"}, q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_chal(input string nm, input logic [7:0] ch, input logic want_rst, input int budget);
    int n;
    n = 0;
    while (!(busy === 1'b1 && scr_challenge === ch && scr_rst === want_rst) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, n < budget, 1'b1);
  endtask

  int s1;

  initial begin
    #1;
    do_reset();

    // Sweep 1: nominal A5 stub, ready always high, full-sweep timing.
    @(posedge clk); #1;
    mask = 8'hA5;
    rand_ready = 1'b0;
    pulse_start(1'b1);
    s1 = sweep_start;
    wait_sweep("sweep1_complete", 3000);
    chk("sweep1_done_cycle", done_seen - s1, SWEEP * (S + 2));

    // Sweep 2: backpressure on CRP 03, then a start pulse while busy.
    mask = 8'($urandom);
    pulse_start(1'b1);
    wait_chal("bp_find_chal03", 8'h03, 1'b1, 200);
    force_low = 1'b1;
    repeat (S + 1 + 10) @(posedge clk);
    #1 force_low = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    pulse_start(1'b0);
    wait_sweep("sweep2_complete", 3000);

    // Sweep 3: random response mask, random ready.
    mask = 8'($urandom);
    rand_ready = 1'b1;
    pulse_start(1'b1);
    wait_sweep("sweep3_complete", 8000);

    // Abort during SETTLE of challenge 10, then restart from the start value.
    mask = 8'($urandom);
    rand_ready = 1'b0;
    pulse_start(1'b1);
    wait_chal("abort_find_chal10", 8'h10, 1'b0, 400);
    do_reset();
    @(posedge clk); #1;
    mask = 8'($urandom);
    rand_ready = 1'b1;
    pulse_start(1'b1);
    wait_sweep("sweep5_complete", 8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #600000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
